// File: rtl/regfile_mp.sv
// Multi-port register file for the 8-bit CPU datapath: two write ports
// (ALU, load), RD_PORTS combinational read ports, optional hardwired zero
// register, optional write-to-read bypass and a per-register busy scoreboard.
module regfile_mp #(
    parameter int unsigned REG_WIDTH = 8,
    parameter int unsigned REG_COUNT = 8,
    parameter int unsigned RD_PORTS  = 2,
    parameter int unsigned ZERO_REG  = 0,
    parameter int unsigned BYPASS    = 1,
    localparam int unsigned AW       = $clog2(REG_COUNT)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [1:0]                    we,
    input  logic [2*AW-1:0]               wr_addr,
    input  logic [2*REG_WIDTH-1:0]        wr_data,
    input  logic [RD_PORTS*AW-1:0]        rd_addr,
    output logic [RD_PORTS*REG_WIDTH-1:0] rd_data,
    output logic [RD_PORTS-1:0]           rd_busy,
    input  logic                          rsv_en,
    input  logic [AW-1:0]                 rsv_addr,
    output logic [REG_COUNT-1:0]          busy,
    output logic                          wr_collide
);

    localparam bit ZR = (ZERO_REG != 0);
    localparam bit BP = (BYPASS != 0);

    logic [AW-1:0]        w_wa [2];
    logic [REG_WIDTH-1:0] w_wd [2];
    logic [1:0]           w_wv;
    logic                 w_rv;
    logic                 w_collide;
    logic [REG_COUNT-1:0] w_busy_nxt;

    logic [REG_WIDTH-1:0] r_regs [REG_COUNT];
    logic [REG_COUNT-1:0] r_busy;
    logic                 r_collide;

    // Unpack write ports; a write is accepted unless reset is active or it
    // targets the hardwired zero register.
    for (genvar p = 0; p < 2; p++) begin : g_wr
        assign w_wa[p] = wr_addr[p*AW +: AW];
        assign w_wd[p] = wr_data[p*REG_WIDTH +: REG_WIDTH];
        assign w_wv[p] = !rst && we[p] && !(ZR && (w_wa[p] == '0));
    end

    assign w_rv      = !rst && rsv_en && !(ZR && (rsv_addr == '0));
    assign w_collide = w_wv[0] && w_wv[1] && (w_wa[0] == w_wa[1]);

    // Scoreboard next state: writes retire, a same-cycle reserve is newer and wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_wv[0]) w_busy_nxt[w_wa[0]] = 1'b0;
        if (w_wv[1]) w_busy_nxt[w_wa[1]] = 1'b0;
        if (w_rv)    w_busy_nxt[rsv_addr] = 1'b1;
        if (ZR)      w_busy_nxt[0] = 1'b0;
    end

    // Register array; load port is written last so it wins a collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(REG_COUNT); i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (w_wv[0]) r_regs[w_wa[0]] <= w_wd[0];
            if (w_wv[1]) r_regs[w_wa[1]] <= w_wd[1];
        end
    end

    // Scoreboard and collision pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy    <= '0;
            r_collide <= 1'b0;
        end else begin
            r_busy    <= w_busy_nxt;
            r_collide <= w_collide;
        end
    end

    assign busy       = r_busy;
    assign wr_collide = r_collide;

    // Read ports: zero register, then bypass (load over ALU), then storage.
    for (genvar k = 0; k < int'(RD_PORTS); k++) begin : g_rd
        logic [AW-1:0]        w_ra;
        logic                 w_hit0;
        logic                 w_hit1;
        logic                 w_rsv_hit;
        logic [REG_WIDTH-1:0] w_rd;

        assign w_ra      = rd_addr[k*AW +: AW];
        assign w_hit0    = BP && w_wv[0] && (w_wa[0] == w_ra);
        assign w_hit1    = BP && w_wv[1] && (w_wa[1] == w_ra);
        assign w_rsv_hit = w_rv && (rsv_addr == w_ra);

        assign w_rd = (ZR && (w_ra == '0)) ? '0 :
                      w_hit1               ? w_wd[1] :
                      w_hit0               ? w_wd[0] :
                                             r_regs[w_ra];

        assign rd_data[k*REG_WIDTH +: REG_WIDTH] = w_rd;
        assign rd_busy[k] = r_busy[w_ra] && !((w_hit0 || w_hit1) && !w_rsv_hit);
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a table of per-cycle vectors against the default
// configuration (ZERO_REG=0, BYPASS=1), with registered results checked via
// a queue, plus hand sequences against a ZERO_REG=1, BYPASS=0 instance.
module tb_regfile_mp;

    logic        clk;
    logic        rst;
    logic [1:0]  we;
    logic [5:0]  wr_addr;
    logic [15:0] wr_data;
    logic [5:0]  rd_addr;
    logic        rsv_en;
    logic [2:0]  rsv_addr;

    logic [15:0] m_rd_data, a_rd_data;
    logic [1:0]  m_rd_busy, a_rd_busy;
    logic [7:0]  m_busy, a_busy;
    logic        m_col, a_col;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        bit         chk;
        logic       rst;
        logic [1:0] we;
        logic [2:0] wa0;
        logic [7:0] wd0;
        logic [2:0] wa1;
        logic [7:0] wd1;
        logic [2:0] ra0;
        logic [2:0] ra1;
        logic       rsv;
        logic [2:0] rsa;
        logic [7:0] e_rd0;
        logic [7:0] e_rd1;
        logic [1:0] e_rdb;
        logic [7:0] e_busy;
        logic       e_col;
    } vec_t;

    typedef struct {
        logic [7:0] busy;
        logic       col;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    regfile_mp u_dut (
        .clk(clk), .rst(rst), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(m_rd_data), .rd_busy(m_rd_busy),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy(m_busy), .wr_collide(m_col)
    );

    regfile_mp #(.ZERO_REG(1), .BYPASS(0)) u_alt (
        .clk(clk), .rst(rst), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy(a_busy), .wr_collide(a_col)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t v(bit chk, logic r, logic [1:0] w,
                               logic [2:0] wa0, logic [7:0] wd0,
                               logic [2:0] wa1, logic [7:0] wd1,
                               logic [2:0] ra0, logic [2:0] ra1,
                               logic rsv, logic [2:0] rsa,
                               logic [7:0] erd0, logic [7:0] erd1, logic [1:0] erdb,
                               logic [7:0] ebusy, logic ecol);
        vec_t t;
        t.chk = chk; t.rst = r; t.we = w;
        t.wa0 = wa0; t.wd0 = wd0; t.wa1 = wa1; t.wd1 = wd1;
        t.ra0 = ra0; t.ra1 = ra1; t.rsv = rsv; t.rsa = rsa;
        t.e_rd0 = erd0; t.e_rd1 = erd1; t.e_rdb = erdb;
        t.e_busy = ebusy; t.e_col = ecol;
        return t;
    endfunction

    task automatic drive(input vec_t t);
        rst      = t.rst;
        we       = t.we;
        wr_addr  = {t.wa1, t.wa0};
        wr_data  = {t.wd1, t.wd0};
        rd_addr  = {t.ra1, t.ra0};
        rsv_en   = t.rsv;
        rsv_addr = t.rsa;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t e;
        drive(v(0,1,0, 0,0, 0,0, 0,0, 0,0, 0,0,0, 0,0));

        //        chk rst we  wa0 wd0    wa1 wd1    ra0 ra1 rsv rsa  rd0    rd1    rdb    busy   col
        vecs.push_back(v(0,1,2'b00, 0,8'h00, 0,8'h00, 0,0, 0,0, 8'h00,8'h00,2'b00, 8'h00,0));
        vecs.push_back(v(1,1,2'b00, 0,8'h00, 0,8'h00, 0,7, 0,0, 8'h00,8'h00,2'b00, 8'h00,0));
        vecs.push_back(v(1,0,2'b00, 0,8'h00, 0,8'h00, 0,1, 0,0, 8'h00,8'h00,2'b00, 8'h00,0));
        vecs.push_back(v(1,0,2'b00, 0,8'h00, 0,8'h00, 2,3, 0,0, 8'h00,8'h00,2'b00, 8'h00,0));
        vecs.push_back(v(1,0,2'b00, 0,8'h00, 0,8'h00, 4,5, 0,0, 8'h00,8'h00,2'b00, 8'h00,0));
        vecs.push_back(v(1,0,2'b00, 0,8'h00, 0,8'h00, 6,7, 0,0, 8'h00,8'h00,2'b00, 8'h00,0));
        vecs.push_back(v(1,0,2'b11, 3,8'h11, 5,8'h22, 3,5, 0,0, 8'h11,8'h22,2'b00, 8'h00,0));
        vecs.push_back(v(1,0,2'b11, 4,8'h33, 4,8'h44, 3,5, 0,0, 8'h11,8'h22,2'b00, 8'h00,1));
        vecs.push_back(v(1,0,2'b00, 0,8'h00, 0,8'h00, 4,3, 0,0, 8'h44,8'h11,2'b00, 8'h00,0));
        vecs.push_back(v(1,0,2'b11, 1,8'h01, 1,8'h02, 1,4, 0,0, 8'h02,8'h44,2'b00, 8'h00,1));
        vecs.push_back(v(1,0,2'b11, 6,8'h07, 6,8'h08, 1,6, 0,0, 8'h02,8'h08,2'b00, 8'h00,1));
        vecs.push_back(v(1,0,2'b01, 2,8'hA5, 0,8'h00, 2,6, 0,0, 8'hA5,8'h08,2'b00, 8'h00,0));
        vecs.push_back(v(1,0,2'b00, 0,8'h00, 0,8'h00, 6,0, 1,6, 8'h08,8'h00,2'b00, 8'h40,0));
        vecs.push_back(v(1,0,2'b00, 0,8'h00, 0,8'h00, 6,5, 0,0, 8'h08,8'h22,2'b01, 8'h40,0));
        vecs.push_back(v(1,0,2'b01, 6,8'h66, 0,8'h00, 6,6, 0,0, 8'h66,8'h66,2'b00, 8'h00,0));
        vecs.push_back(v(1,0,2'b10, 0,8'h00, 6,8'h77, 6,7, 1,6, 8'h77,8'h00,2'b00, 8'h40,0));
        vecs.push_back(v(1,0,2'b01, 6,8'h88, 0,8'h00, 6,6, 1,6, 8'h88,8'h88,2'b11, 8'h40,0));
        vecs.push_back(v(1,0,2'b00, 0,8'h00, 0,8'h00, 6,0, 0,0, 8'h88,8'h00,2'b01, 8'h40,0));
        vecs.push_back(v(1,0,2'b00, 0,8'h00, 0,8'h00, 1,7, 1,1, 8'h02,8'h00,2'b00, 8'h42,0));
        vecs.push_back(v(1,0,2'b00, 0,8'h00, 0,8'h00, 1,7, 1,7, 8'h02,8'h00,2'b01, 8'hC2,0));
        vecs.push_back(v(0,1,2'b11, 1,8'h5A, 1,8'h5A, 1,6, 0,0, 8'h00,8'h00,2'b00, 8'h00,0));
        vecs.push_back(v(1,0,2'b00, 0,8'h00, 0,8'h00, 1,6, 0,0, 8'h00,8'h00,2'b00, 8'h00,0));

        #1;
        foreach (vecs[i]) begin
            drive(vecs[i]);
            e.busy = vecs[i].e_busy;
            e.col  = vecs[i].e_col;
            sb.push_back(e);
            #4;
            if (vecs[i].chk) begin
                chk($sformatf("v%0d rd0", i), 32'(m_rd_data[7:0]),  32'(vecs[i].e_rd0));
                chk($sformatf("v%0d rd1", i), 32'(m_rd_data[15:8]), 32'(vecs[i].e_rd1));
                chk($sformatf("v%0d rd_busy", i), 32'(m_rd_busy), 32'(vecs[i].e_rdb));
            end
            tick();
            if (sb.size() == 0) begin
                chk($sformatf("v%0d scoreboard empty", i), 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk($sformatf("v%0d busy", i),       32'(m_busy), 32'(e.busy));
                chk($sformatf("v%0d wr_collide", i), 32'(m_col),  32'(e.col));
            end
        end

        // Bypass vs no bypass: 0xA5 to r2 read in the same cycle.
        drive(v(0,0,2'b01, 2,8'hA5, 0,8'h00, 2,0, 0,0, 0,0,0, 0,0));
        #4;
        chk("byp same-cycle main", 32'(m_rd_data[7:0]), 32'h00A5);
        chk("nobyp same-cycle alt", 32'(a_rd_data[7:0]), 32'h0000);
        tick();
        drive(v(0,0,2'b00, 0,8'h00, 0,8'h00, 2,0, 0,0, 0,0,0, 0,0));
        #4;
        chk("byp next-cycle main", 32'(m_rd_data[7:0]), 32'h00A5);
        chk("nobyp next-cycle alt", 32'(a_rd_data[7:0]), 32'h00A5);
        tick();

        // Zero register: write 0xFF to r0 and reserve r0.
        drive(v(0,0,2'b01, 0,8'hFF, 0,8'h00, 0,0, 1,0, 0,0,0, 0,0));
        #4;
        chk("zero wr main rd0", 32'(m_rd_data[7:0]), 32'h00FF);
        chk("zero wr alt rd0",  32'(a_rd_data[7:0]), 32'h0000);
        chk("zero wr alt rd_busy", 32'(a_rd_busy), 32'h0);
        tick();
        chk("zero alt busy", 32'(a_busy), 32'h00);
        chk("zero main busy", 32'(m_busy), 32'h01);
        drive(v(0,0,2'b00, 0,8'h00, 0,8'h00, 0,0, 0,0, 0,0,0, 0,0));
        #4;
        chk("zero main rd0 stored", 32'(m_rd_data[7:0]), 32'h00FF);
        chk("zero alt rd0 stored",  32'(a_rd_data[7:0]), 32'h0000);
        chk("zero main rd_busy", 32'(m_rd_busy), 32'h3);
        chk("zero alt rd_busy",  32'(a_rd_busy), 32'h0);
        tick();

        // Collision on address 0: counted only without the zero register.
        drive(v(0,0,2'b11, 0,8'h01, 0,8'h02, 0,2, 0,0, 0,0,0, 0,0));
        tick();
        chk("col0 main wr_collide", 32'(m_col), 32'h1);
        chk("col0 alt wr_collide",  32'(a_col), 32'h0);
        chk("col0 main busy", 32'(m_busy), 32'h00);
        drive(v(0,0,2'b00, 0,8'h00, 0,8'h00, 0,2, 0,0, 0,0,0, 0,0));
        #4;
        chk("col0 main rd0", 32'(m_rd_data[7:0]), 32'h0002);
        chk("col0 alt rd0",  32'(a_rd_data[7:0]), 32'h0000);
        chk("col0 alt rd1",  32'(a_rd_data[15:8]), 32'h00A5);
        tick();
        chk("col0 main wr_collide drop", 32'(m_col), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the 8-bit CPU datapath. It replaces the single-write, dual-read file with a configurable number of read ports and two write ports (ALU result and load return). It adds an optional hardwired zero register, optional write-to-read bypass, and a per-register busy scoreboard that the decode stage uses to stall on outstanding writes.

## Interface
- REG_WIDTH, 8, data width of each register
- REG_COUNT, 8, number of registers (power of two, ≥2); AW = $clog2(REG_COUNT)
- RD_PORTS, 2, number of independent read ports (1..4)
- ZERO_REG, 0, 1 = register 0 always reads 0, ignores writes, never busy
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- we  in  2  write enables; bit0 = ALU port, bit1 = load port
- wr_addr  in  2*AW  write addresses; port p at [p*AW +: AW]
- wr_data  in  2*REG_WIDTH  write data; port p at [p*REG_WIDTH +: REG_WIDTH]
- rd_addr  in  RD_PORTS*AW  read addresses, packed as above
- rd_data  out  RD_PORTS*REG_WIDTH  read data, combinational
- rd_busy  out  RD_PORTS  busy flag of each read port's addressed register, combinational
- rsv_en  in  1  reserve: mark rsv_addr busy (destination of an issued long-latency op)
- rsv_addr  in  AW  register to reserve
- busy  out  REG_COUNT  registered scoreboard, bit i = register i has a pending write
- wr_collide  out  1  registered 1-cycle pulse: both write ports enabled to the same address

## Operation
- Writes: on each rising edge, for each port p with we[p]=1, registers[wr_addr_p] <= wr_data_p.
- Both ports writing the same address in one cycle: port 1 (load) wins. wr_collide=1 in the following cycle.
- ZERO_REG=1: writes, reservations and collisions targeting address 0 are ignored. rd_data for address 0 = 0. busy[0] is held at 0.
- Read port k: if BYPASS=1 and a same-cycle write targets rd_addr_k, it returns that write's data (port 1 data if both ports write it). Otherwise it returns the stored value.
- Scoreboard:
  - rsv_en sets busy[rsv_addr].
  - Any accepted write clears busy[wr_addr].
  - Reserve and write to the same address in the same cycle: the register ends busy (the reserve belongs to a newer op), and the data is still written.
  - Reserving an already-busy register is legal; it stays busy.
- rd_busy[k] = busy[rd_addr_k]. When BYPASS=1, it is forced to 0 if a same-cycle write targets rd_addr_k and there is no same-cycle reserve of that address.
- rst=1 overrides we and rsv_en in that cycle.

## Timing
- Reset values:
  - all registers = 0
  - busy = 0
  - wr_collide = 0
  - rd_data = 0 while rst is applied from the first edge onward (registers cleared)
- Read latency 0: rd_data and rd_busy follow rd_addr and, with BYPASS=1, we, wr_addr and wr_data combinationally.
- Write latency 1: without bypass, data is visible on reads from the cycle after the edge.
- busy update latency 1 edge. A reserve in cycle n is visible on busy in cycle n+1.
- wr_collide asserts for exactly one cycle per colliding cycle. Back-to-back collisions keep it high continuously.
- Reset mid-operation: pending reservations are discarded, and writes in the reset cycle are lost.

## Test plan
- Reset then read all registers:
  - apply rst for 2 cycles; read addresses 0..7 on both ports -> all 0, busy=0x00, wr_collide=0.
- Dual write and collision:
  - cycle 1: we=2'b11, addr0=3, data0=0x11, addr1=5, data1=0x22; next cycle r3=0x11, r5=0x22, wr_collide=0.
  - cycle 2: both ports write addr 4 (0x33 on port 0, 0x44 on port 1) -> r4=0x44, wr_collide=1 for one cycle.
- Bypass:
  - BYPASS=1: write 0xA5 to r2 while rd_addr=2 in the same cycle -> rd_data=0xA5 that cycle.
  - BYPASS=0: same stimulus -> old value 0x00 that cycle, 0xA5 next cycle.
- Zero register, ZERO_REG=1:
  - write 0xFF to r0 and rsv_en with rsv_addr=0 -> rd_data for r0 stays 0, busy[0]=0.
  - same stimulus with ZERO_REG=0 -> r0 reads 0xFF.
- Scoreboard:
  - rsv r6 -> busy=0x40 next cycle, rd_busy=1 for reads of r6.
  - a write to r6 alone clears busy[6] next cycle; with BYPASS=1, rd_busy=0 already in the write cycle.
  - a write to r6 plus a reserve of r6 in the same cycle leaves busy[6]=1.
- Reset mid-operation:
  - reserve r1 and r7, then assert rst in the same cycle as a write of 0x5A to r1 -> busy=0x00 and r1=0x00 after the edge.
